iomem_audio_fifo: RTL
=====================

// Module: iomem_audio_fifo
// PURPOSE
//  Memory-mapped stereo sample FIFO on the picosoc iomem bus, beside the GPIO slave at prefix 0x03.
//  Firmware pushes packed {L,R} 16-bit samples through iomem writes.
//  The codec/I2S stage pops one sample pair per sample_req strobe.
//  Provides status, sticky error flags and a low-watermark IRQ for the CPU's irq_5 line.
// PARAMETERS
//  ADDR_PREFIX  8'h04  iomem_addr[31:24] value decoded by this slave
//  DEPTH_LOG2   6      FIFO depth = 2**DEPTH_LOG2 sample pairs (64)
//  SAMPLE_W     16     bits per channel; one pair packs into 32-bit wdata
// PORTS
//  clk           in   1         system clock (same clock as picosoc)
//  reset         in   1         asynchronous, active-high reset
//  iomem_valid   in   1         bus request
//  iomem_ready   out  1         one-cycle acknowledge
//  iomem_wstrb   in   4         byte write strobes; 0 = read
//  iomem_addr    in   32        byte address; [31:24]=prefix, [3:2]=register
//  iomem_wdata   in   32        write data
//  iomem_rdata   out  32        read data, valid while iomem_ready=1
//  sample_req    in   1         one-cycle pop strobe from codec stage
//  sample_l      out  SAMPLE_W  left sample, held between pops
//  sample_r      out  SAMPLE_W  right sample, held between pops
//  sample_valid  out  1         one-cycle pulse: new pair on sample_l/r
//  irq           out  1         level IRQ: enable & irq_en & (level <= thresh)
// BEHAVIOUR
//  Reset (async, any cycle, mid-transfer included):
//   - outputs 0 (iomem_ready, iomem_rdata, sample_*, irq)
//   - FIFO emptied, CTRL=0, sticky flags cleared
//  Bus handshake:
//   - accept when valid & !ready & addr[31:24]==ADDR_PREFIX
//   - iomem_ready=1 exactly next cycle, for one cycle; other prefixes never acked
//  Register map (addr[3:2]):
//   - 0 DATA (W): wstrb==4'hF pushes {L=wdata[31:16], R=wdata[15:0]}; partial strobes ignored; read returns 0
//   - 1 STATUS (R): [31:16] level, [3] overflow, [2] underrun, [1] full, [0] empty
//   - 1 STATUS (W): wstrb[0] & wdata[2]/[3] clears underrun/overflow (write-1-clear)
//   - 2 CTRL (RW): [0] enable, [1] flush (self-clearing, reads 0), [2] irq_en, [15:8] irq_thresh
//   - 3: reads 0, writes ignored
//  FIFO:
//   - circular buffer, DEPTH_LOG2-bit wr/rd pointers wrapping modulo depth
//   - level is DEPTH_LOG2+1 bits, range 0..DEPTH
//   - push when full: data dropped, overflow<=1, pointers unchanged
//  Pop (sample_req in cycle N, enable=1):
//   - non-empty: sample_l/r <= head, sample_valid=1 in N+1
//   - empty: sample_l/r <= 0, sample_valid=1, underrun<=1
//   - enable=0: sample_req ignored, sample_valid stays 0, outputs hold
//  Simultaneous events:
//   - push+pop same cycle: both occur, level unchanged; applies when full (pop frees slot, push succeeds)
//   - when empty, the pop sees empty (no bypass)
//   - flush has priority over same-cycle push/pop: pointers->0, level->0; sample outputs hold
//   - W1C and flag-set in same cycle: set wins
//  irq_thresh compare: zero-extended to level width
//  Storage: inferred as BRAM; read registered, one-cycle latency folded into the N+1 timing above
// STRUCTURE
//  Shared package audio_pkg:
//   - register offsets (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2)
//   - STATUS/CTRL bit positions
//   - SAMPLE_W default
//  One sub-module: sync_fifo (DATA_W=2*SAMPLE_W, DEPTH_LOG2)
//   - ports: push, pop, flush, full, empty, level
//  Bus decode, registers and pop/underrun logic stay in the top
// TESTING
//  1. Reset mid-write (valid high) -> no ready after reset; STATUS reads 0x0000_0001
//  2. Push 0x1234_ABCD, 0x5555_AAAA; pulse sample_req twice (enable=1)
//     -> L/R = 0x1234/0xABCD then 0x5555/0xAAAA, each with one sample_valid; level 2->0
//  3. Push 65 words -> full=1, level=64, overflow=1; 65th word never popped
//     -> W1C 0x8 clears overflow
//  4. Full FIFO, push+sample_req same cycle -> push accepted, level stays 64, overflow stays 0
//  5. Empty FIFO, sample_req -> L/R=0, sample_valid=1, underrun=1
//     -> with enable=0, no sample_valid
//  6. thresh=4, irq_en=1: level 5->4 via pop -> irq rises next cycle
//     -> flush via CTRL=0x0405|0x2 -> level=0, irq stays 1

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the iomem audio sample FIFO:
// register map, STATUS/CTRL bit positions and defaults.
package audio_pkg;

   localparam int SAMPLE_W_DEF = 16;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_e;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_UNDERRUN  = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_LEVEL_LSB = 16;

   localparam int CT_ENABLE     = 0;
   localparam int CT_FLUSH      = 1;
   localparam int CT_IRQ_EN     = 2;
   localparam int CT_THRESH_LSB = 8;

   typedef struct packed {
      logic [7:0] thresh;
      logic       irq_en;
      logic       enable;
   } ctrl_t;

   function automatic logic [31:0] ctrl_word(input ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CT_ENABLE] = c.enable;
      w[CT_IRQ_EN] = c.irq_en;
      w[CT_THRESH_LSB +: 8] = c.thresh;
      return w;
   endfunction

endpackage

// File: rtl/iomem_audio_fifo_sync_fifo.sv
// Circular-buffer FIFO with registered read port, so the
// storage maps onto block RAM; flush beats push and pop.
module sync_fifo
   import audio_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW = DEPTH_LOG2 + 1;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);

   // Storage write; no reset so it stays a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Registered head read; when full and pushing, the
   // shared address returns the old head (read-first).
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if (do_pop)
         rd_data <= mem[rd_ptr];
   end

endmodule

// File: rtl/iomem_audio_fifo.sv
// picosoc iomem slave feeding stereo sample pairs to the
// codec stage, with status, sticky errors and level IRQ.
module iomem_audio_fifo
   import audio_pkg::*;
#(
   parameter logic [7:0] ADDR_PREFIX = 8'h04,
   parameter int         DEPTH_LOG2  = 6,
   parameter int         SAMPLE_W    = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   input  logic                sample_req,
   output logic [SAMPLE_W-1:0] sample_l,
   output logic [SAMPLE_W-1:0] sample_r,
   output logic                sample_valid,
   output logic                irq
);

   localparam int LW = DEPTH_LOG2 + 1;
   localparam int DW = 2 * SAMPLE_W;

   ctrl_t         ctrl;
   logic          overflow;
   logic          underrun;
   logic          zero_out;
   logic [DW-1:0] head;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic          sel;
   logic          is_wr;
   reg_e          rsel;
   logic          push_req;
   logic          ctrl_wr;
   logic          st_clr;
   logic          flush;
   logic          pop_req;
   logic          pop_fire;
   logic          ovf_set;
   logic          unr_set;
   logic [31:0]   rd_word;
   logic          unused_bits;

   assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0],
                          iomem_wdata[31:16],
                          iomem_wdata[7:3]};

   assign sel = iomem_valid & ~iomem_ready &
                (iomem_addr[31:24] == ADDR_PREFIX);
   assign rsel  = reg_e'(iomem_addr[3:2]);
   assign is_wr = |iomem_wstrb;

   assign push_req = sel & (rsel == REG_DATA) &
                     (iomem_wstrb == 4'hF);
   assign ctrl_wr  = sel & (rsel == REG_CTRL) & is_wr;
   assign st_clr   = sel & (rsel == REG_STATUS) &
                     iomem_wstrb[0];
   assign flush    = ctrl_wr & iomem_wstrb[0] &
                     iomem_wdata[CT_FLUSH];

   assign pop_req  = sample_req & ctrl.enable & ~flush;
   assign pop_fire = pop_req & ~empty;
   assign unr_set  = pop_req & empty;
   assign ovf_set  = push_req & full & ~pop_fire & ~flush;

   sync_fifo #(
      .DATA_W     (DW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_req),
      .wr_data (iomem_wdata[DW-1:0]),
      .pop     (pop_req),
      .flush   (flush),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // Read data mux for the register being accessed.
   always_comb begin
      rd_word = '0;
      if (!is_wr) begin
         unique case (rsel)
            REG_STATUS: begin
               rd_word[ST_LEVEL_LSB +: 16] = 16'(level);
               rd_word[ST_OVERFLOW] = overflow;
               rd_word[ST_UNDERRUN] = underrun;
               rd_word[ST_FULL]     = full;
               rd_word[ST_EMPTY]    = empty;
            end
            REG_CTRL: rd_word = ctrl_word(ctrl);
            REG_DATA: rd_word = '0;
            REG_RSVD: rd_word = '0;
         endcase
      end
   end

   // One-cycle acknowledge with registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
      end else begin
         iomem_ready <= sel;
         iomem_rdata <= sel ? rd_word : '0;
      end
   end

   // CTRL register and sticky flags; a set beats a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl     <= '0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (ctrl_wr && iomem_wstrb[0]) begin
            ctrl.enable <= iomem_wdata[CT_ENABLE];
            ctrl.irq_en <= iomem_wdata[CT_IRQ_EN];
         end
         if (ctrl_wr && iomem_wstrb[1])
            ctrl.thresh <= iomem_wdata[CT_THRESH_LSB +: 8];
         overflow <= ovf_set | (overflow &
                     ~(st_clr & iomem_wdata[ST_OVERFLOW]));
         underrun <= unr_set | (underrun &
                     ~(st_clr & iomem_wdata[ST_UNDERRUN]));
      end
   end

   // Pop strobe and underrun zeroing of the output pair.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_valid <= 1'b0;
         zero_out     <= 1'b0;
      end else begin
         sample_valid <= pop_req;
         if (pop_req)
            zero_out <= empty;
      end
   end

   assign sample_l = zero_out ? '0 : head[DW-1:SAMPLE_W];
   assign sample_r = zero_out ? '0 : head[SAMPLE_W-1:0];

   assign irq = ctrl.enable & ctrl.irq_en &
                (32'(level) <= 32'(ctrl.thresh));

endmodule
